// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the round-robin 4-to-2 encoder.
//   state_e    : FSM state encoding (idle / holding a code for the consumer)
//   REQ_NONE   : active-low request bus with no request asserted
//   NREQ       : number of request lines
//   count_ones : population count of a 4-bit active-high request vector
//   next_ptr   : round-robin pointer successor of a granted index (wraps 3->0)
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int         NREQ     = 4;
  localparam logic [3:0] REQ_NONE = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Number of asserted bits in an active-high request vector.
  function automatic logic [2:0] count_ones(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Pointer for the next arbitration round: one past the granted index,
  // relying on 2-bit wrap so that index 3 returns to 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker over four active-high requests.
// Ports:
//   req   [3:0] in  : active-high request vector
//   ptr   [1:0] in  : index with highest priority this round
//   idx   [1:0] out : first active index scanning ptr, ptr+1, ... mod 4
//                     (equals ptr when no request is active)
//   any         out : at least one request active
//   multi       out : more than one request active
// -----------------------------------------------------------------------------
module rr_pick4
  import enc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any,
  output logic       multi
);

  logic [1:0] w_idx;
  logic [1:0] w_pos;

  // Scan offsets from farthest to nearest so the nearest active index to
  // ptr is the last one written and therefore wins.
  always_comb begin
    w_idx = ptr;
    w_pos = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = ptr + k[1:0];
      w_idx = req[w_pos] ? w_pos : w_idx;
    end
  end

  assign idx   = w_idx;
  assign any   = |req;
  assign multi = (count_ones(req) > 3'd1);

endmodule

// File: rtl/encoder42_rr.sv
// -----------------------------------------------------------------------------
// encoder42_rr
// Sequential 4-to-2 encoder with round-robin selection and a valid/ack
// handshake. Inputs follow the 2-to-4 decoder's active-low output convention,
// so decoding {a,b} with enable low reproduces a single-request pattern.
// Ports:
//   clk          in  : rising-edge clock
//   rst          in  : asynchronous reset, active-high
//   en_n         in  : active-low enable; high idles the block and aborts a
//                      pending grant (abort wins over a simultaneous ack)
//   req_n  [3:0] in  : active-low requests
//   ack          in  : consumer accepts the presented code (only while valid)
//   a            out : code MSB (registered)
//   b            out : code LSB (registered)
//   valid        out : code is being presented (registered)
//   multi        out : more than one request was active at capture (registered)
// a/b/multi keep their last values while valid is low.
// -----------------------------------------------------------------------------
module encoder42_rr
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_n,
  input  logic [3:0] req_n,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       multi
);

  state_e     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_grant;
  logic       r_a;
  logic       r_b;
  logic       r_valid;
  logic       r_multi;

  logic [3:0] w_req_act;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_multi;

  // Invert requests to active-high; only a definite 0 counts as active so an
  // unknown request bit can never be granted or reach a/b.
  always_comb begin
    w_req_act = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      w_req_act[i] = (req_n[i] === 1'b0);
    end
  end

  rr_pick4 u_pick (
    .req   (w_req_act),
    .ptr   (r_ptr),
    .idx   (w_idx),
    .any   (w_any),
    .multi (w_multi)
  );

  // Handshake FSM: capture in IDLE, hold the frozen code in HOLD until ack
  // (advance pointer) or abort via en_n (pointer untouched).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_grant <= 2'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!en_n && w_any) begin
            r_state <= ST_HOLD;
            r_grant <= w_idx;
            r_a     <= w_idx[1];
            r_b     <= w_idx[0];
            r_multi <= w_multi;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (en_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else if (ack) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_ptr   <= next_ptr(r_grant);
          end else begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule
